// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one n-way mux among n_cell requesters.
// The winning word is captured into a one-entry valid/ready output register.
module rr_mux_arbiter #(
   parameter int unsigned switch_bits = 2,
   parameter int unsigned data_width  = 8,
   localparam int unsigned n_cell     = 1 << switch_bits
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [n_cell-1:0]              req,
   input  logic [n_cell*data_width-1:0]   in_data,
   output logic [n_cell-1:0]              gnt,
   output logic [switch_bits-1:0]         sel,
   output logic                           out_valid,
   output logic [data_width-1:0]          out_data,
   input  logic                           out_ready
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [switch_bits-1:0] ptr_q, ptr_d;
   logic [switch_bits-1:0] sel_q, sel_d;
   logic [data_width-1:0]  data_q, data_d;
   logic [switch_bits-1:0] win_c;
   logic [switch_bits-1:0] idx_c;
   logic                   found_c;
   logic                   cap_c;
   logic [n_cell-1:0]      gnt_c;

   // First requester at or after ptr, wrapping modulo n_cell.
   always_comb begin
      win_c   = '0;
      found_c = 1'b0;
      idx_c   = '0;
      for (int k = 0; k < int'(n_cell); k++) begin
         idx_c = ptr_q + switch_bits'(k);
         if (!found_c && req[idx_c]) begin
            win_c   = idx_c;
            found_c = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      gnt_c   = '0;
      cap_c   = (|req) && (state_q == IDLE || out_ready);
      if (cap_c) begin
         gnt_c[win_c] = 1'b1;
         data_d       = in_data[win_c*data_width +: data_width];
         sel_d        = win_c;
         ptr_d        = win_c + switch_bits'(1);
         state_d      = HOLD;
      end else if (state_q == HOLD && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

   // Grant is suppressed while reset is held so it reads 0 before any edge.
   assign gnt       = rst ? '0 : gnt_c;
   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_mux_arbiter;

   localparam int unsigned SB = 2;
   localparam int unsigned DW = 8;
   localparam int unsigned N  = 1 << SB;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req;
   logic [N*DW-1:0]   in_data;
   logic [N-1:0]      gnt;
   logic [SB-1:0]     sel;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_ready;

   int n_cmp = 0;
   int n_err = 0;

   // Model state
   int            m_ptr;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [SB-1:0] m_sel;
   // Model next values and expected grant for the current cycle
   int            n_ptr;
   logic          n_valid;
   logic [DW-1:0] n_data;
   logic [SB-1:0] n_sel;
   logic [N-1:0]  e_gnt;
   logic [N-1:0]  g_obs;

   rr_mux_arbiter #(.switch_bits(SB), .data_width(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt),
      .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = '0;
   endfunction

   // Evaluate the spec rules on the current inputs.
   function automatic void model_eval();
      int w;
      bit cap;
      w = -1;
      for (int k = 0; k < int'(N); k++) begin
         int i;
         i = (m_ptr + k) % int'(N);
         if (w < 0 && req[i]) w = i;
      end
      cap = (req != '0) && (!m_valid || out_ready);
      n_ptr = m_ptr; n_valid = m_valid; n_data = m_data; n_sel = m_sel;
      e_gnt = '0;
      if (cap) begin
         e_gnt[w] = 1'b1;
         n_data   = in_data[w*DW +: DW];
         n_sel    = SB'(w);
         n_ptr    = (w + 1) % int'(N);
         n_valid  = 1'b1;
      end else if (m_valid && out_ready) begin
         n_valid = 1'b0;
      end
   endfunction

   function automatic void model_commit();
      m_ptr = n_ptr; m_valid = n_valid; m_data = n_data; m_sel = n_sel;
   endfunction

   // One clock: drive at negedge, sample gnt before the edge, settle after it.
   task automatic cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic rdy);
      @(negedge clk);
      req = r; in_data = d; out_ready = rdy;
      #1;
      g_obs = gnt;
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_init_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_init_data got %h want 00", out_data); end
      n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL rst_init_sel got %0d want 0", sel); end
      cycle(4'b0001, 32'h0000_005A, 1'b1);
      cycle(4'b0100, 32'h0000_0000, 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
         n_err++; $display("FAIL rst_pre_hold got v=%b d=%h want v=1 d=5a", out_valid, out_data);
      end
      @(negedge clk);
      req = 4'b0110;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_async_data got %h want 00", out_data); end
      n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL rst_async_sel got %0d want 0", sel); end
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_async_gnt got %b want 0000", gnt); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(4'b1100, 32'h4433_2211, 1'b1);
      n_cmp++; if (g_obs !== 4'b0100) begin n_err++; $display("FAIL rst_first_gnt got %b want 0100", g_obs); end
      n_cmp++; if (out_data !== 8'h33 || sel !== 2'd2) begin
         n_err++; $display("FAIL rst_first_cap got d=%h s=%0d want d=33 s=2", out_data, sel);
      end
   endtask

   task automatic test_single();
      do_reset();
      cycle(4'b0010, 32'h0000_3C00, 1'b1);
      n_cmp++; if (g_obs !== 4'b0010) begin n_err++; $display("FAIL single_gnt got %b want 0010", g_obs); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C || sel !== 2'd1) begin
         n_err++; $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=3c s=1", out_valid, out_data, sel);
      end
      cycle(4'b1111, 32'h0000_0000, 1'b1);
      n_cmp++; if (g_obs !== 4'b0100) begin n_err++; $display("FAIL single_ptr got gnt %b want 0100", g_obs); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_d;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cycle(4'b1111, 32'h1312_1110, 1'b1);
         exp_d = 8'h10 + 8'(c % 4);
         n_cmp++; if (g_obs !== 4'(1 << (c % 4))) begin
            n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", c, g_obs, 4'(1 << (c % 4)));
         end
         n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
            n_err++; $display("FAIL rr_data[%0d] got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, exp_d);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cycle(4'b0100, 32'h0077_0000, 1'b1);
      for (int c = 0; c < 5; c++) begin
         cycle(4'b0001, 32'h0000_0001, 1'b0);
         n_cmp++; if (g_obs !== 4'b0000) begin n_err++; $display("FAIL bp_gnt[%0d] got %b want 0000", c, g_obs); end
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h77 || sel !== 2'd2) begin
            n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=77 s=2", c, out_valid, out_data, sel);
         end
      end
      cycle(4'b0001, 32'h0000_0001, 1'b1);
      n_cmp++; if (g_obs !== 4'b0001) begin n_err++; $display("FAIL bp_release_gnt got %b want 0001", g_obs); end
      n_cmp++; if (out_data !== 8'h01 || sel !== 2'd0) begin
         n_err++; $display("FAIL bp_release_data got d=%h s=%0d want d=01 s=0", out_data, sel);
      end
   endtask

   task automatic test_drain();
      cycle(4'b0000, 32'hFFFF_FFFF, 1'b1);
      n_cmp++; if (g_obs !== 4'b0000) begin n_err++; $display("FAIL drain_gnt got %b want 0000", g_obs); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h01 || sel !== 2'd0) begin
         n_err++; $display("FAIL drain_keep got d=%h s=%0d want d=01 s=0", out_data, sel);
      end
      cycle(4'b0000, 32'h0000_0000, 1'b0);
      n_cmp++; if (g_obs !== 4'b0000 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL idle_stay got gnt=%b v=%b want gnt=0000 v=0", g_obs, out_valid);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cycle(4'b1001, 32'hA300_00A0, 1'b1);
         n_cmp++; if (g_obs !== ((c % 2 == 0) ? 4'b0001 : 4'b1000)) begin
            n_err++; $display("FAIL fair_gnt[%0d] got %b want %b", c, g_obs, (c % 2 == 0) ? 4'b0001 : 4'b1000);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0]    r;
      logic [N*DW-1:0] d;
      logic            rdy;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         r   = N'($urandom);
         d   = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         cycle(r, d, rdy);
         n_cmp++; if (g_obs !== e_gnt) begin n_err++; $display("FAIL rand_gnt[%0d] got %b want %b", c, g_obs, e_gnt); end
         n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rand_valid[%0d] got %b want %b", c, out_valid, m_valid); end
         n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", c, out_data, m_data); end
         n_cmp++; if (sel !== m_sel) begin n_err++; $display("FAIL rand_sel[%0d] got %0d want %0d", c, sel, m_sel); end
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; in_data = '0; out_ready = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_drain();
      test_fairness();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one n-way mux datapath among `n_cell` requesters. Each cycle it can pick one requesting source, drive that source's index as the mux select, and capture the selected word into a one-entry output register. A valid/ready handshake presents the word downstream. It sits in front of the processing datapath wherever several producers feed one consumer through a mux.

## Interface
- `switch_bits`, 2, width of the select index; `n_cell = 1 << switch_bits` requesters.
- `data_width`, 8, width of each data word.
- `n_cell`, `1 << switch_bits`, derived; not overridden.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  n_cell  request per source; bit i high means `in_data` slice i is valid.
- `in_data`  in  n_cell*data_width  flattened source words; source i occupies bits `[i*data_width +: data_width]`.
- `gnt`  out  n_cell  one-hot capture acknowledge; combinational, high only in the capture cycle.
- `sel`  out  switch_bits  registered index of the source whose word is in `out_data`.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_data`  out  data_width  registered captured word.
- `out_ready`  in  1  downstream accepts `out_data` when `out_valid && out_ready`.

## Operation
- State is `IDLE` (output register empty) or `HOLD` (output register full).
- Priority pointer `ptr` (switch_bits wide) names the highest-priority source.
- Winner `w` is the first i with `req[i]=1`, scanning `ptr, ptr+1, …, n_cell-1, 0, …, ptr-1` (mod n_cell).
- Capture condition `cap = (|req) && (state==IDLE || out_ready)`.
- On `cap`:
  - `gnt[w]=1` combinationally in that cycle.
  - At the clock edge: `out_data <= in_data[w]`, `sel <= w`, `ptr <= w+1` (wraps mod n_cell), `out_valid <= 1`, state becomes `HOLD`.
- `HOLD` with `out_ready=1` and no request: `out_valid <= 0`, state becomes `IDLE`; `out_data` and `sel` keep their last values.
- `HOLD` with `out_ready=0`: all registers hold and `gnt=0`, whatever `req` does.
- `IDLE` with no request: nothing changes and `gnt=0`.
- Requester rules:
  - A requester keeps `req` high and its data stable until it sees its `gnt` bit.
  - It may deassert `req` in the cycle after `gnt`, or keep it high to offer a new word.
  - A request dropped before `gnt` is simply skipped; the block does not check for this.
- Fairness: after source i is granted it has the lowest priority. Any continuously asserted request is granted within n_cell captures.
- `out_valid` equals `state==HOLD`, so the two cannot disagree.
- Reset (asynchronous, any time, including mid-transfer):
  - Outputs: `out_valid=0`, `out_data=0`, `sel=0`, `gnt=0`.
  - Internal: `ptr=0`, state `IDLE`.
  - Any in-flight word is discarded.
  - The first capture can occur on the first rising edge after `rst` falls.

## Timing
- Latency: request to `out_valid` is 1 cycle when the output register is empty.
- `gnt` is asserted in the same cycle as the capturing edge.
- Back-to-back: while `out_ready` stays high and requests are present, one word transfers per cycle with no bubble.
- When `out_ready=1` in `HOLD`, the current word is consumed and the next word is captured at the same edge. Consume and refill are simultaneous, so there is no overflow.
- `gnt` depends combinationally on `req`, `ptr`, `state` and `out_ready`. There is no combinational path from `in_data` to any output.
- Pointer wrap: `w = n_cell-1` sets `ptr` to 0.

## Test plan
Parameters for all cases: switch_bits=2, data_width=8.
- Reset: assert `rst` mid-`HOLD` with `out_valid=1` and `out_data=0x5A` -> `out_valid=0`, `out_data=0`, `sel=0`, `gnt=0` immediately, before any clock edge; the first capture after release comes from the lowest requesting index at or above 0.
- Single requester: `req=0010`, slice 1 = `0x3C`, `out_ready=1` -> `gnt=0010` that cycle; next cycle `out_valid=1`, `out_data=0x3C`, `sel=1`; `ptr` becomes 2.
- Round-robin with wrap: `req=1111` held, `out_ready=1`, slices `0x10,0x11,0x12,0x13` -> grants in order 0,1,2,3,0,…; `out_data` sequence `0x10,0x11,0x12,0x13,0x10` on consecutive cycles with no bubble.
- Backpressure: capture `0x77` from source 2, then hold `out_ready=0` for 5 cycles with `req=0001` -> `gnt=0`, and `out_data=0x77` and `sel=2` stay stable for all 5 cycles. When `out_ready` rises -> `gnt=0001` that cycle and `out_data=0x01` next cycle.
- Drain to idle: `HOLD`, `out_ready=1`, `req=0000` -> `out_valid` falls next cycle; `out_data` and `sel` retain their last values; `gnt` stays 0.
- Fairness under contention: `req=1001` constant, `ptr=0` -> grants alternate 0,3,0,3; neither source waits more than 1 capture.
